// File: rtl/bmp_slave_tx_if.sv
// Slave-port bus between one bmp_slave_tx and one arbiter slave input (mode, proc, valid/data, ready).
// Latency: pure wiring, no storage.
// Backpressure: slv_ready flows from the arbiter (slave modport) back to the transmitter (master modport).
interface bmp_slave_tx_if #(
  parameter int DATA_BUS_SIZE = 32
);
  logic [1:0]               slv_mode;
  logic [7:0]               slv_data_proc;
  logic                     slv_data_valid;
  logic [DATA_BUS_SIZE-1:0] slv_data;
  logic                     slv_ready;

  modport master (
    output slv_mode,
    output slv_data_proc,
    output slv_data_valid,
    output slv_data,
    input  slv_ready
  );

  modport slave (
    input  slv_mode,
    input  slv_data_proc,
    input  slv_data_valid,
    input  slv_data,
    output slv_ready
  );
endinterface

// File: rtl/bmp_slave_tx.sv
// Streams one job (mode, proc byte, N words) from an upstream FiFo onto an arbiter slave port.
// Latency: start in N -> src_rd in N+1, first valid in N+3, then 1 word/cycle; done 1 cycle after last beat.
// Backpressure: 2-entry head+skid buffer holds words while slv_ready=0; src_empt only pauses fetching.
module bmp_slave_tx #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int LEN_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [1:0]               job_mode,
  input  logic [7:0]               job_proc,
  input  logic [LEN_W-1:0]         job_len,
  output logic                     job_busy,
  output logic                     job_done,
  output logic                     src_rd,
  input  logic [DATA_BUS_SIZE-1:0] src_data,
  input  logic                     src_empt,
  bmp_slave_tx_if.master           slv
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [7:0]               proc_q, proc_d;
  logic [LEN_W-1:0]         fetch_left_q, fetch_left_d;
  logic [LEN_W-1:0]         send_left_q, send_left_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               occ_q, occ_d;
  logic [DATA_BUS_SIZE-1:0] head_q, head_d;
  logic [DATA_BUS_SIZE-1:0] skid_q, skid_d;

  logic                     vld;
  logic                     beat;
  logic                     rd;
  logic [2:0]               pending;

  assign vld     = (occ_q != 2'd0);
  assign beat    = vld & slv.slv_ready;
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};

  // The slot freed by a beat in this cycle counts as available: without it the
  // pending read would block refetch every other cycle and halve throughput.
  // Buffer occupancy next cycle is then at most 1 plus this read, so never above 2.
  assign rd = (state_q == S_SEND) && (fetch_left_q != '0) && !src_empt &&
              (pending < (beat ? 3'd3 : 3'd2));

  assign src_rd   = rd;
  assign job_busy = (state_q == S_SEND);
  assign job_done = (state_q == S_FINISH);

  assign slv.slv_data_valid = vld;
  assign slv.slv_data       = head_q;
  assign slv.slv_mode       = (state_q == S_SEND) ? mode_q : 2'b00;
  assign slv.slv_data_proc  = (state_q == S_SEND) ? proc_q : 8'h00;

  // Next-state: job sequencing, counters and head/skid buffer bookkeeping.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    proc_d       = proc_q;
    fetch_left_d = fetch_left_q;
    send_left_d  = send_left_q;
    inflight_d   = rd;
    occ_d        = occ_q;
    head_d       = head_q;
    skid_d       = skid_q;

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          mode_d       = job_mode;
          proc_d       = job_proc;
          fetch_left_d = job_len;
          send_left_d  = job_len;
          state_d      = (job_len == '0) ? S_FINISH : S_SEND;
        end
      end
      S_SEND: begin
        if (rd) begin
          fetch_left_d = fetch_left_q - 1'b1;
        end
        if (beat) begin
          send_left_d = send_left_q - 1'b1;
          if (send_left_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Word arriving from the FiFo (inflight_q) versus word leaving (beat).
    case ({beat, inflight_q})
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = src_data;
          occ_d  = 2'd1;
        end else begin
          skid_d = src_data;
          occ_d  = 2'd2;
        end
      end
      2'b10: begin
        if (occ_q == 2'd2) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = skid_q;
          skid_d = src_data;
        end else begin
          head_d = src_data;
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      proc_q       <= 8'h00;
      fetch_left_q <= '0;
      send_left_q  <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      proc_q       <= proc_d;
      fetch_left_q <= fetch_left_d;
      send_left_q  <= send_left_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_bmp_slave_tx.sv
// Directed bench for bmp_slave_tx: cycle traces, backpressure, starvation, reset, max length.
// Latency: checks exact cycle offsets from the accepted start.
// Backpressure: drives slv_ready patterns and a stallable FiFo model.
module tb_bmp_slave_tx;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [1:0]    job_mode;
  logic [7:0]    job_proc;
  logic [LW-1:0] job_len;
  logic          job_busy;
  logic          job_done;
  logic          src_rd;
  logic [DW-1:0] src_data = '0;
  logic          src_empt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bmp_slave_tx_if #(.DATA_BUS_SIZE(DW)) bus ();

  bmp_slave_tx #(.DATA_BUS_SIZE(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_start (job_start),
    .job_mode  (job_mode),
    .job_proc  (job_proc),
    .job_len   (job_len),
    .job_busy  (job_busy),
    .job_done  (job_done),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_empt  (src_empt),
    .slv       (bus)
  );

  // FiFo model: word i = base + i*step, data appears the cycle after src_rd.
  int   fifo_base = 0;
  int   fifo_step = 1;
  int   fifo_cnt  = 0;
  int   rd_idx    = 0;
  logic fifo_load = 1'b0;
  logic force_empt = 1'b0;

  assign src_empt = force_empt | (rd_idx >= fifo_cnt);

  always @(posedge clk) begin
    if (fifo_load) begin
      rd_idx <= 0;
    end else if (src_rd) begin
      src_data <= 32'(fifo_base + rd_idx * fifo_step);
      rd_idx   <= rd_idx + 1;
    end
  end

  // Monitor: counts beats, reads, stalls and protocol violations.
  logic mon_clr = 1'b0;
  int   cyc, beat_cnt, rd_cnt, done_cnt, data_err, stall_err, stall_cnt;
  int   max_out, drop_cnt, drop_bad, last_beat_cyc, done_cyc;
  logic prev_stall, prev_valid, prev_beat;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    int pend;
    if (mon_clr) begin
      cyc = 0; beat_cnt = 0; rd_cnt = 0; done_cnt = 0; data_err = 0;
      stall_err = 0; stall_cnt = 0; max_out = 0; drop_cnt = 0; drop_bad = 0;
      last_beat_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0; prev_valid = 1'b0; prev_beat = 1'b0; prev_data = '0;
    end else begin
      cyc = cyc + 1;
      pend = rd_cnt - beat_cnt;
      if (pend > max_out) max_out = pend;
      if (prev_stall && (!bus.slv_data_valid || bus.slv_data !== prev_data)) stall_err = stall_err + 1;
      if (prev_valid && !bus.slv_data_valid) begin
        if (job_busy) drop_cnt = drop_cnt + 1;
        if (!prev_beat) drop_bad = drop_bad + 1;
      end
      if (bus.slv_data_valid && !bus.slv_ready) stall_cnt = stall_cnt + 1;
      if (src_rd) rd_cnt = rd_cnt + 1;
      if (bus.slv_data_valid && bus.slv_ready) begin
        if (bus.slv_data !== 32'(fifo_base + beat_cnt * fifo_step)) data_err = data_err + 1;
        beat_cnt = beat_cnt + 1;
        last_beat_cyc = cyc;
      end
      if (job_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      prev_stall = bus.slv_data_valid & ~bus.slv_ready;
      prev_valid = bus.slv_data_valid;
      prev_beat  = bus.slv_data_valid & bus.slv_ready;
      prev_data  = bus.slv_data;
    end
  end

  task automatic mon_clear();
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic load_fifo(input int base, input int step, input int cnt);
    @(posedge clk); #1;
    fifo_base = base; fifo_step = step; fifo_cnt = cnt; fifo_load = 1'b1;
    @(posedge clk); #1;
    fifo_load = 1'b0;
  endtask

  task automatic start_job(input int len, input logic [1:0] mode, input logic [7:0] proc);
    @(posedge clk); #1;
    job_start = 1'b1; job_len = LW'(len); job_mode = mode; job_proc = proc;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: job_done seen=0 required=1 within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; job_start = 1'b0; job_mode = 2'b00; job_proc = 8'h00; job_len = '0;
    bus.slv_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (job_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", job_busy); end
    n_cmp++; if (job_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", job_done); end
    n_cmp++; if (src_rd !== 1'b0) begin n_err++; $display("FAIL reset_src_rd: got %b required 0", src_rd); end
    n_cmp++; if (bus.slv_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", bus.slv_data_valid); end
    n_cmp++; if (bus.slv_data !== '0) begin n_err++; $display("FAIL reset_data: got %h required 0", bus.slv_data); end
    n_cmp++; if (bus.slv_mode !== 2'b00) begin n_err++; $display("FAIL reset_mode: got %b required 00", bus.slv_mode); end
    n_cmp++; if (bus.slv_data_proc !== 8'h00) begin n_err++; $display("FAIL reset_proc: got %h required 00", bus.slv_data_proc); end
  endtask

  // Cycle trace: k = offset from the cycle N in which job_start is sampled.
  task automatic test_basic();
    logic [13:0] obs, exp;
    load_fifo(32'h11, 32'h11, 4);
    mon_clear();
    bus.slv_ready = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b1; job_len = 16'd4; job_mode = 2'b01; job_proc = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp = {1'(k >= 1 && k <= 4), 1'(k >= 3 && k <= 6), 1'(k == 7), 1'(k >= 1 && k <= 6),
             (k >= 1 && k <= 6) ? 2'b01 : 2'b00, (k >= 1 && k <= 6) ? 8'hA5 : 8'h00};
      obs = {src_rd, bus.slv_data_valid, job_done, job_busy, bus.slv_mode, bus.slv_data_proc};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL basic_ctrl_N+%0d: {rd,vld,done,busy,mode,proc} got %h required %h", k, obs, exp);
      end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (bus.slv_data !== 32'(32'h11 * (k - 2))) begin
          n_err++;
          $display("FAIL basic_data_N+%0d: got %h required %h", k, bus.slv_data, 32'(32'h11 * (k - 2)));
        end
      end
      @(posedge clk); #1;
      job_start = 1'b0;
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] obs, exp;
    mon_clear();
    @(posedge clk); #1;
    job_start = 1'b1; job_len = 16'd0; job_mode = 2'b11; job_proc = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, 1'(k == 1), 1'b0};
      obs = {src_rd, bus.slv_data_valid, job_done, job_busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL zero_len_N+%0d: {rd,vld,done,busy} got %b required %b", k, obs, exp);
      end
      @(posedge clk); #1;
      job_start = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bit fin;
    fin = 1'b0;
    load_fifo(32'h100, 1, 8);
    mon_clear();
    bus.slv_ready = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b1; job_len = 16'd8; job_mode = 2'b10; job_proc = 8'h3C;
    for (int k = 1; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      job_start = 1'b0;
      bus.slv_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk); #1;
      if (done_cnt > 0) fin = 1'b1;
    end
    bus.slv_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (!fin) begin n_err++; $display("FAIL bp_timeout: job_done seen=0 required=1"); end
    n_cmp++; if (beat_cnt != 8) begin n_err++; $display("FAIL bp_beats: got %0d required 8", beat_cnt); end
    n_cmp++; if (data_err != 0) begin n_err++; $display("FAIL bp_order: bad words %0d required 0", data_err); end
    n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stable: unstable stalls %0d required 0", stall_err); end
    n_cmp++; if (stall_cnt == 0) begin n_err++; $display("FAIL bp_stalled: stall cycles %0d required >0", stall_cnt); end
    n_cmp++; if (max_out > 2) begin n_err++; $display("FAIL bp_outstanding: max %0d required <=2", max_out); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_starve();
    bit fin;
    fin = 1'b0;
    load_fifo(32'h200, 1, 6);
    mon_clear();
    bus.slv_ready = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b1; job_len = 16'd6; job_mode = 2'b01; job_proc = 8'h77;
    for (int k = 1; k < 100 && !fin; k++) begin
      @(posedge clk); #1;
      job_start = 1'b0;
      force_empt = (k >= 3 && k <= 7);
      @(negedge clk); #1;
      if (done_cnt > 0) fin = 1'b1;
    end
    force_empt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (!fin) begin n_err++; $display("FAIL starve_timeout: job_done seen=0 required=1"); end
    n_cmp++; if (beat_cnt != 6) begin n_err++; $display("FAIL starve_beats: got %0d required 6", beat_cnt); end
    n_cmp++; if (data_err != 0) begin n_err++; $display("FAIL starve_order: bad words %0d required 0", data_err); end
    n_cmp++; if (drop_cnt < 1) begin n_err++; $display("FAIL starve_drained: valid drops %0d required >=1", drop_cnt); end
    n_cmp++; if (drop_bad != 0) begin n_err++; $display("FAIL starve_retract: drops without beat %0d required 0", drop_bad); end
    n_cmp++; if (done_cyc != last_beat_cyc + 1) begin n_err++; $display("FAIL starve_done_cyc: got %0d required %0d", done_cyc, last_beat_cyc + 1); end
  endtask

  task automatic test_ignored_start();
    logic [1:0] mode_mid;
    mode_mid = 2'b00;
    load_fifo(32'h300, 1, 8);
    mon_clear();
    bus.slv_ready = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b1; job_len = 16'd3; job_mode = 2'b01; job_proc = 8'h99;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 4) mode_mid = bus.slv_mode;
      @(posedge clk); #1;
      job_start = ((k + 1) == 2) || ((k + 1) == 6);
      if (job_start) begin
        job_len = 16'd5; job_mode = 2'b10; job_proc = 8'h3C;
      end
    end
    job_start = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (beat_cnt != 3) begin n_err++; $display("FAIL ignored_beats: got %0d required 3", beat_cnt); end
    n_cmp++; if (rd_cnt != 3) begin n_err++; $display("FAIL ignored_reads: got %0d required 3", rd_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignored_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++; if (mode_mid !== 2'b01) begin n_err++; $display("FAIL ignored_mode: got %b required 01", mode_mid); end
    n_cmp++; if (job_busy !== 1'b0) begin n_err++; $display("FAIL ignored_idle: busy got %b required 0", job_busy); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    logic [46:0] obs;
    hit = 1'b0;
    load_fifo(32'h400, 1, 5);
    mon_clear();
    bus.slv_ready = 1'b1;
    start_job(5, 2'b11, 8'hC3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (beat_cnt >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rstmid_timeout: beats got %0d required 2", beat_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    obs = {job_busy, job_done, src_rd, bus.slv_data_valid, bus.slv_mode, bus.slv_data_proc, bus.slv_data};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: {busy,done,rd,vld,mode,proc,data} got %h required 0", obs);
    end
    load_fifo(32'h500, 1, 2);
    mon_clear();
    start_job(2, 2'b01, 8'h11);
    wait_done("rstmid_new", 20);
    n_cmp++; if (beat_cnt != 2) begin n_err++; $display("FAIL rstmid_new_beats: got %0d required 2", beat_cnt); end
    n_cmp++; if (data_err != 0) begin n_err++; $display("FAIL rstmid_new_order: bad words %0d required 0", data_err); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rstmid_new_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_max_len();
    load_fifo(0, 1, 70000);
    mon_clear();
    bus.slv_ready = 1'b1;
    start_job(32'hFFFF, 2'b10, 8'hF0);
    wait_done("max", 66000);
    n_cmp++; if (beat_cnt != 65535) begin n_err++; $display("FAIL max_beats: got %0d required 65535", beat_cnt); end
    n_cmp++; if (data_err != 0) begin n_err++; $display("FAIL max_order: bad words %0d required 0", data_err); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL max_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++; if (max_out > 2) begin n_err++; $display("FAIL max_outstanding: max %0d required <=2", max_out); end
    n_cmp++; if (done_cyc != last_beat_cyc + 1) begin n_err++; $display("FAIL max_done_cyc: got %0d required %0d", done_cyc, last_beat_cyc + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_starve();
    test_ignored_start();
    test_reset_mid();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
